// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in serial-out shift transmitter; optional parity bit via PISO_PARITY_EN
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [FRAME-1:0] sreg;   // frame bits, next bit to send sits at the output end
  logic [CW-1:0]    cnt;    // bits sent so far, including the one on sout now
  logic             last_bit;
  logic             accept;

  // Arrange a word into send order; parity (if enabled) trails the data bits.
  function automatic logic [FRAME-1:0] build_frame(input logic [WIDTH-1:0] d);
`ifdef PISO_PARITY_EN
    if (MSB_FIRST != 0) return {d, ^d};
    else                return {^d, d};
`else
    return d;
`endif
  endfunction

  // Advance by one bit, filling with zeros so an empty register drives sout=0.
  function automatic logic [FRAME-1:0] shift_once(input logic [FRAME-1:0] s);
    if (MSB_FIRST != 0) return {s[FRAME-2:0], 1'b0};
    else                return {1'b0, s[FRAME-1:1]};
  endfunction

  assign last_bit   = (state == SHIFT) && (cnt == LAST_CNT);
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;
  assign busy       = (state == SHIFT);
  assign sout_valid = (state == SHIFT);
  assign done       = last_bit;
  assign sout       = (MSB_FIRST != 0) ? sreg[FRAME-1] : sreg[0];

  // Frame sequencing: load on accept, shift one bit per clock, return idle after the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      sreg  <= build_frame(din);
      cnt   <= CW'(1);
    end else if (state == SHIFT) begin
      if (last_bit) begin
        state <= IDLE;
        sreg  <= '0;
        cnt   <= '0;
      end else begin
        sreg <= shift_once(sreg);
        cnt  <= cnt + CW'(1);
      end
    end
  end

endmodule
